btn_event_gen: RTL



---
 rtl/btn_evt_pkg.sv | 32 +++
 rtl/btn_event_gen.sv | 135 +++++++++++++
 2 files changed

// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg
// Shared definitions for the button event generator:
//   - state_t      : FSM state encoding (IDLE, PRESSED, HELD)
//   - LONG_CNT_DEF : default hold cycles from press to long-press event
//   - REPEAT_CNT_DEF : default cycles between auto-repeat events
//   - cnt_width()  : width of the hold counter for a given pair of thresholds
package btn_evt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  localparam int LONG_CNT_DEF   = 50_000_000;
  localparam int REPEAT_CNT_DEF = 10_000_000;

  // The counter only ever holds values 0 .. max(long,repeat)-1, so
  // $clog2 of the larger threshold is enough; never narrower than 1 bit.
  function automatic int cnt_width(input int long_cnt, input int repeat_cnt);
    int max_cnt;
    int width;
    max_cnt = (long_cnt > repeat_cnt) ? long_cnt : repeat_cnt;
    if (max_cnt <= 2) begin
      width = 1;
    end else begin
      width = $clog2(max_cnt);
    end
    return width;
  endfunction

endpackage

// File: rtl/btn_event_gen.sv
// btn_event_gen
// Turns the debounced level of one button into single-cycle event pulses.
//
// Ports:
//   clk           in  system clock
//   reset         in  synchronous, active-high reset
//   btn_level     in  debounced button level, synchronous to clk
//   enable        in  event generation enable; low forces IDLE
//   press_pulse   out one cycle on a qualified rising edge
//   release_pulse out one cycle on release from PRESSED or HELD
//   short_pulse   out one cycle on release before the long threshold
//   long_pulse    out one cycle when the long threshold is reached
//   repeat_pulse  out one cycle every REPEAT_CNT cycles while HELD
//   held          out high while the FSM is in HELD
//
// Parameters:
//   LONG_CNT   hold cycles from press to long_pulse (>= 2)
//   REPEAT_CNT cycles between repeat_pulse events while held (>= 1)
//   CNT_W      hold counter width
module btn_event_gen
  import btn_evt_pkg::*;
#(
  parameter int LONG_CNT   = LONG_CNT_DEF,
  parameter int REPEAT_CNT = REPEAT_CNT_DEF,
  parameter int CNT_W      = cnt_width(LONG_CNT, REPEAT_CNT)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  input  logic enable,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             prev_r;

  // Event FSM with its single hold counter and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      // Starting at 1 means a button already down when reset lifts
      // must be seen low before a press can be qualified.
      prev_r        <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      // prev tracks the input even while disabled, so re-enabling with the
      // button down does not fabricate a rising edge.
      prev_r        <= btn_level;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      if (!enable) begin
        state_r <= IDLE;
        cnt_r   <= CNT_ZERO;
        held    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            held <= 1'b0;
            if (btn_level && !prev_r) begin
              press_pulse <= 1'b1;
              cnt_r       <= CNT_ZERO;
              state_r     <= PRESSED;
            end else begin
              state_r     <= IDLE;
            end
          end

          PRESSED: begin
            // Release is tested first so it wins over the long threshold.
            if (!btn_level) begin
              release_pulse <= 1'b1;
              short_pulse   <= 1'b1;
              cnt_r         <= CNT_ZERO;
              held          <= 1'b0;
              state_r       <= IDLE;
            end else if (cnt_r == LONG_LAST) begin
              long_pulse    <= 1'b1;
              cnt_r         <= CNT_ZERO;
              held          <= 1'b1;
              state_r       <= HELD;
            end else begin
              cnt_r         <= cnt_r + CNT_ONE;
              held          <= 1'b0;
            end
          end

          HELD: begin
            // Release wins over a coinciding repeat threshold.
            if (!btn_level) begin
              release_pulse <= 1'b1;
              cnt_r         <= CNT_ZERO;
              held          <= 1'b0;
              state_r       <= IDLE;
            end else if (cnt_r == REPEAT_LAST) begin
              repeat_pulse  <= 1'b1;
              cnt_r         <= CNT_ZERO;
              held          <= 1'b1;
            end else begin
              cnt_r         <= cnt_r + CNT_ONE;
              held          <= 1'b1;
            end
          end

          default: begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            held    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
